// File: rtl/attack_sequencer.sv
// attack_sequencer
//   Per-player attack controller. Each fighter walks through STARTUP, ACTIVE
//   and RECOVERY phases (light or heavy timing), lands at most one hit per
//   attack while the opponent is in range, and is knocked into HITSTUN when
//   struck. All state advances only on clk edges qualified by the game tick.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   tick                  one-clk game-tick enable
//   game_active           0 forces both players idle and suppresses hits
//   pN_light, pN_heavy    attack buttons (level, edge-detected per tick)
//   pN_in_range           opponent is inside player N's hit range
//   pN_state              phase code (see table)
//   pN_heavy_sel          current attack is heavy
//   pN_hit, pN_damage     hit strobe (one tick period) and its damage
//   pN_busy               player is not idle
//
// state      | meaning
// -----------+-------------------------------------------
// S_IDLE     | no attack; accepts a new request
// S_STARTUP  | wind-up, cannot hit yet
// S_ACTIVE   | hitbox live; one hit may land
// S_RECOVERY | cool-down after the active window
// S_HITSTUN  | struck, locked out until the counter expires
module attack_sequencer #(
  parameter int unsigned LIGHT_STARTUP  = 2,
  parameter int unsigned LIGHT_ACTIVE   = 2,
  parameter int unsigned LIGHT_RECOVERY = 3,
  parameter int unsigned HEAVY_STARTUP  = 4,
  parameter int unsigned HEAVY_ACTIVE   = 2,
  parameter int unsigned HEAVY_RECOVERY = 6,
  parameter int unsigned HITSTUN        = 5,
  parameter int unsigned LIGHT_DMG      = 10,
  parameter int unsigned HEAVY_DMG      = 25,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       game_active,
  input  logic       p1_light,
  input  logic       p1_heavy,
  input  logic       p2_light,
  input  logic       p2_heavy,
  input  logic       p1_in_range,
  input  logic       p2_in_range,
  output logic [2:0] p1_state,
  output logic [2:0] p2_state,
  output logic       p1_heavy_sel,
  output logic       p2_heavy_sel,
  output logic       p1_hit,
  output logic [8:0] p1_damage,
  output logic       p2_hit,
  output logic [8:0] p2_damage,
  output logic       p1_busy,
  output logic       p2_busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STARTUP  = 3'd1,
    S_ACTIVE   = 3'd2,
    S_RECOVERY = 3'd3,
    S_HITSTUN  = 3'd4
  } phase_e;

  localparam logic [8:0] LDMG = 9'(LIGHT_DMG);
  localparam logic [8:0] HDMG = 9'(HEAVY_DMG);

  function automatic logic [CNT_W-1:0] ld(input int unsigned dur);
    return CNT_W'(dur - 1);
  endfunction

  // Index 0 is player 1, index 1 is player 2.
  phase_e           state_q [2];
  phase_e           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [8:0]       dmg_q   [2];
  logic [8:0]       dmg_d   [2];
  logic [1:0]       heavy_q, heavy_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       hit_q, hit_d;
  logic [1:0]       light_prev_q, heavy_prev_q;

  logic [1:0] light_b, heavy_b, edge_l, edge_h, land, struck;

  assign light_b = {p2_light, p1_light};
  assign heavy_b = {p2_heavy, p1_heavy};
  assign edge_l  = light_b & ~light_prev_q;
  assign edge_h  = heavy_b & ~heavy_prev_q;

  assign land[0] = game_active && (state_q[0] == S_ACTIVE) && !done_q[0] && p1_in_range;
  assign land[1] = game_active && (state_q[1] == S_ACTIVE) && !done_q[1] && p2_in_range;
  // A player is struck by whatever the opponent lands this tick.
  assign struck  = {land[0], land[1]};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      heavy_d[i] = heavy_q[i];
      done_d[i]  = done_q[i] | land[i];
      hit_d[i]   = land[i];
      dmg_d[i]   = land[i] ? (heavy_q[i] ? HDMG : LDMG) : 9'd0;

      if (!game_active) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        heavy_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end else if (struck[i]) begin
        // Cancels any attack; also re-arms the lockout if already stunned.
        state_d[i] = S_HITSTUN;
        cnt_d[i]   = ld(HITSTUN);
        heavy_d[i] = 1'b0;
      end else begin
        if (state_q[i] != S_IDLE && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
        unique case (state_q[i])
          S_IDLE: begin
            if (edge_h[i] || edge_l[i]) begin
              state_d[i] = S_STARTUP;
              heavy_d[i] = edge_h[i];
              cnt_d[i]   = edge_h[i] ? ld(HEAVY_STARTUP) : ld(LIGHT_STARTUP);
              done_d[i]  = 1'b0;
            end
          end
          S_STARTUP: begin
            if (cnt_q[i] == '0) begin
              state_d[i] = S_ACTIVE;
              cnt_d[i]   = heavy_q[i] ? ld(HEAVY_ACTIVE) : ld(LIGHT_ACTIVE);
            end
          end
          S_ACTIVE: begin
            if (cnt_q[i] == '0) begin
              state_d[i] = S_RECOVERY;
              cnt_d[i]   = heavy_q[i] ? ld(HEAVY_RECOVERY) : ld(LIGHT_RECOVERY);
            end
          end
          S_RECOVERY: begin
            if (cnt_q[i] == '0) begin
              state_d[i] = S_IDLE;
              heavy_d[i] = 1'b0;
            end
          end
          S_HITSTUN: begin
            if (cnt_q[i] == '0) state_d[i] = S_IDLE;
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= '{default: S_IDLE};
      cnt_q        <= '{default: '0};
      dmg_q        <= '{default: '0};
      heavy_q      <= '0;
      done_q       <= '0;
      hit_q        <= '0;
      light_prev_q <= '0;
      heavy_prev_q <= '0;
    end else if (tick) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmg_q        <= dmg_d;
      heavy_q      <= heavy_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
      // History tracks the buttons even while the game is paused.
      light_prev_q <= light_b;
      heavy_prev_q <= heavy_b;
    end
  end

  assign p1_state     = state_q[0];
  assign p2_state     = state_q[1];
  assign p1_heavy_sel = heavy_q[0];
  assign p2_heavy_sel = heavy_q[1];
  assign p1_hit       = hit_q[0];
  assign p2_hit       = hit_q[1];
  assign p1_damage    = dmg_q[0];
  assign p2_damage    = dmg_q[1];
  assign p1_busy      = (state_q[0] != S_IDLE);
  assign p2_busy      = (state_q[1] != S_IDLE);

endmodule

// File: tb/tb_attack_sequencer.sv
// Testbench for attack_sequencer: phase-level reference model checked every
// clock, plus literal expectations for the directed scenarios.
module tb_attack_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick, game_active;
  logic       p1_light, p1_heavy, p2_light, p2_heavy, p1_in_range, p2_in_range;
  logic [2:0] p1_state, p2_state;
  logic       p1_heavy_sel, p2_heavy_sel, p1_hit, p2_hit, p1_busy, p2_busy;
  logic [8:0] p1_damage, p2_damage;

  attack_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .game_active(game_active),
    .p1_light(p1_light), .p1_heavy(p1_heavy), .p2_light(p2_light), .p2_heavy(p2_heavy),
    .p1_in_range(p1_in_range), .p2_in_range(p2_in_range),
    .p1_state(p1_state), .p2_state(p2_state),
    .p1_heavy_sel(p1_heavy_sel), .p2_heavy_sel(p2_heavy_sel),
    .p1_hit(p1_hit), .p1_damage(p1_damage), .p2_hit(p2_hit), .p2_damage(p2_damage),
    .p1_busy(p1_busy), .p2_busy(p2_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: phase number, ticks left in that phase, heavy flag, hit landed.
  int m_ph [2];
  int m_left [2];
  bit m_hv [2];
  bit m_done [2];
  bit m_pl [2];
  bit m_phv [2];
  bit e_hit [2];
  int e_dmg [2];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dur(input int ph, input bit hv);
    case (ph)
      1: return hv ? 4 : 2;
      2: return 2;
      3: return hv ? 6 : 3;
      default: return 5;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_ph[p] = 0; m_left[p] = 0; m_hv[p] = 0; m_done[p] = 0;
      m_pl[p] = 0; m_phv[p] = 0; e_hit[p] = 0; e_dmg[p] = 0;
    end
  endtask

  task automatic model_step();
    bit lt [2];
    bit hb [2];
    bit rg [2];
    bit el [2];
    bit eh [2];
    bit landed [2];
    lt[0] = p1_light; lt[1] = p2_light;
    hb[0] = p1_heavy; hb[1] = p2_heavy;
    rg[0] = p1_in_range; rg[1] = p2_in_range;
    for (int p = 0; p < 2; p++) begin
      el[p] = lt[p] && !m_pl[p];
      eh[p] = hb[p] && !m_phv[p];
      m_pl[p] = lt[p];
      m_phv[p] = hb[p];
      landed[p] = game_active && m_ph[p] == 2 && !m_done[p] && rg[p];
      e_hit[p] = landed[p];
      e_dmg[p] = landed[p] ? (m_hv[p] ? 25 : 10) : 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (!game_active) begin
        m_ph[p] = 0; m_left[p] = 0; m_hv[p] = 0; m_done[p] = 0;
      end else if (landed[1-p]) begin
        m_ph[p] = 4; m_left[p] = 5; m_hv[p] = 0;
      end else if (m_ph[p] == 0) begin
        if (el[p] || eh[p]) begin
          m_ph[p] = 1; m_hv[p] = eh[p]; m_left[p] = dur(1, eh[p]); m_done[p] = 0;
        end
      end else begin
        m_left[p]--;
        if (m_left[p] == 0) begin
          m_ph[p] = (m_ph[p] >= 3) ? 0 : m_ph[p] + 1;
          if (m_ph[p] != 0) m_left[p] = dur(m_ph[p], m_hv[p]);
          else m_hv[p] = 0;
        end
      end
      if (landed[p]) m_done[p] = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("p1_state", int'(p1_state), m_ph[0]);
      check("p2_state", int'(p2_state), m_ph[1]);
      check("p1_heavy_sel", int'(p1_heavy_sel), int'(m_hv[0]));
      check("p2_heavy_sel", int'(p2_heavy_sel), int'(m_hv[1]));
      check("p1_hit", int'(p1_hit), int'(e_hit[0]));
      check("p2_hit", int'(p2_hit), int'(e_hit[1]));
      check("p1_damage", int'(p1_damage), e_dmg[0]);
      check("p2_damage", int'(p2_damage), e_dmg[1]);
      check("p1_busy", int'(p1_busy), int'(m_ph[0] != 0));
      check("p2_busy", int'(p2_busy), int'(m_ph[1] != 0));
    end
  end

  // One game tick with the given buttons; returns just after the tick edge.
  task automatic step(input bit a_l1, input bit a_h1, input bit a_l2, input bit a_h2,
                      input bit a_ga);
    @(negedge clk);
    p1_light = a_l1; p1_heavy = a_h1; p2_light = a_l2; p2_heavy = a_h2;
    game_active = a_ga;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    model_step();
  endtask

  task automatic gap();
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 0, 0, 0, 1);
      gap();
    end
  endtask

  int s1_p1 [9] = '{1, 1, 2, 2, 3, 3, 3, 0, 0};
  int s1_hit [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
  int s1_p2 [9] = '{0, 0, 0, 4, 4, 4, 4, 4, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, starts, prev, p2_hits;
    reset = 1'b1; tick = 1'b0; game_active = 1'b0;
    p1_light = 0; p1_heavy = 0; p2_light = 0; p2_heavy = 0;
    p1_in_range = 0; p2_in_range = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_p1_state", int'(p1_state), 0);
    check("reset_p2_state", int'(p2_state), 0);
    check("reset_p1_hit", int'(p1_hit), 0);
    check("reset_p2_damage", int'(p2_damage), 0);
    chk_en = 1'b1;
    reset = 1'b0;
    idle(2);

    // Light attack, p1 in range, p2 idle.
    p1_in_range = 1; p2_in_range = 0;
    for (int k = 0; k < 9; k++) begin
      step(k == 0, 0, 0, 0, 1);
      check("s1_p1_state", int'(p1_state), s1_p1[k]);
      check("s1_p1_hit", int'(p1_hit), s1_hit[k]);
      check("s1_p1_damage", int'(p1_damage), s1_hit[k] * 10);
      check("s1_p2_state", int'(p2_state), s1_p2[k]);
      gap();
    end

    // Heavy and light on the same tick: heavy timing and damage.
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(k == 0, k == 0, 0, 0, 1);
      if (p1_busy) busy_cnt++;
      if (k == 0) check("s2_heavy_sel", int'(p1_heavy_sel), 1);
      if (k == 3) check("s2_last_startup", int'(p1_state), 1);
      if (k == 4) check("s2_first_active", int'(p1_state), 2);
      if (k == 5) check("s2_damage", int'(p1_damage), 25);
      gap();
    end
    check("s2_busy_ticks", busy_cnt, 12);

    // p2 starts two ticks later and is hit during its startup.
    p1_in_range = 1; p2_in_range = 1;
    p2_hits = 0;
    for (int k = 0; k < 12; k++) begin
      step(k == 0, 0, k == 2, 0, 1);
      if (p2_hit) p2_hits++;
      if (k == 3) begin
        check("s3_p1_hit", int'(p1_hit), 1);
        check("s3_p2_state", int'(p2_state), 4);
      end
      if (k == 4) check("s3_p1_recovery", int'(p1_state), 3);
      gap();
    end
    check("s3_p2_never_hits", p2_hits, 0);

    // Simultaneous presses trade.
    for (int k = 0; k < 10; k++) begin
      step(k == 0, 0, k == 0, 0, 1);
      if (k == 3) begin
        check("s4_p1_hit", int'(p1_hit), 1);
        check("s4_p2_hit", int'(p2_hit), 1);
        check("s4_p1_damage", int'(p1_damage), 10);
        check("s4_p2_damage", int'(p2_damage), 10);
        check("s4_p1_state", int'(p1_state), 4);
        check("s4_p2_state", int'(p2_state), 4);
      end
      gap();
    end

    // Button held for 20 ticks fires once.
    p1_in_range = 0; p2_in_range = 0;
    starts = 0; prev = int'(p1_state);
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0, 0, 1);
      if (p1_state == 3'd1 && prev != 1) starts++;
      prev = int'(p1_state);
      gap();
    end
    check("s5_one_attack", starts, 1);
    step(0, 0, 0, 0, 1); gap();
    step(1, 0, 0, 0, 1); gap();
    check("s5_restart", int'(p1_state), 1);
    p1_in_range = 1;
    step(1, 0, 0, 0, 0); gap();
    check("s5_pause_idle", int'(p1_state), 0);
    check("s5_pause_nohit", int'(p1_hit), 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 1);
      check("s5_resume_held", int'(p1_state), 0);
      gap();
    end

    // Press during recovery is dropped.
    p1_in_range = 0;
    step(0, 0, 0, 0, 1); gap();
    for (int k = 0; k < 10; k++) begin
      step(k == 0 || k >= 5, 0, 0, 0, 1);
      if (k == 5) check("s6_recovery", int'(p1_state), 3);
      if (k == 7 || k == 9) check("s6_dropped", int'(p1_state), 0);
      gap();
    end

    // Asynchronous reset while p1 is in ACTIVE.
    step(0, 0, 0, 0, 1); gap();
    p1_in_range = 1;
    for (int k = 0; k < 3; k++) begin
      step(k == 0, 0, 0, 0, 1);
      if (k < 2) gap();
    end
    check("s7_pre_active", int'(p1_state), 2);
    #2;
    p1_light = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check("s7_async_p1_state", int'(p1_state), 0);
    check("s7_async_p1_busy", int'(p1_busy), 0);
    check("s7_async_p1_hit", int'(p1_hit), 0);
    check("s7_async_p2_state", int'(p2_state), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
